// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   Truth-table sweeper for a 4-input / 1-output combinational function block.
//   On an accepted START it steps {A,B,C,D} through minterms 0..15. Each
//   minterm is held for SETTLE_CYCLES+1 cycles, and F_IN is sampled on the
//   last edge of that hold. The captured table is then compared against the
//   EXP mask that was latched at START.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   sweep request, honoured only while idle
//   EXP[15:0]  in   expected truth table (bit i = minterm i), latched at START
//   F_IN       in   output of the function under check
//   A,B,C,D    out  current minterm, A = MSB, D = LSB
//   BUSY       out  high from accepted START through the DONE cycle
//   DONE       out  one-cycle pulse when results become valid
//   PASS       out  captured table equals latched EXP
//   CAPT[15:0] out  captured truth table
//   MISMATCH   out  CAPT xor latched EXP
//   FIRST_ERR  out  lowest set index of MISMATCH (0 if none)
//   ERR_VALID  out  any MISMATCH bit set
module tt_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [15:0] EXP,
    input  logic        F_IN,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] CAPT,
    output logic [15:0] MISMATCH,
    output logic [3:0]  FIRST_ERR,
    output logic        ERR_VALID
);

    localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic        accept;
    logic        sample;
    logic        last;
    logic [15:0] capt_nxt;
    logic [15:0] mis_nxt;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) res = i[3:0];
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        capt_nxt  = CAPT;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == SETTLE) begin
                    sample        = 1'b1;
                    capt_nxt[idx] = F_IN;
                    if (idx == 4'd15) begin
                        last      = 1'b1;
                        state_nxt = FIN;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The comparison is taken from the table including the minterm-15 sample
    // that lands on the same edge, so results are ready in the DONE cycle.
    assign mis_nxt = capt_nxt ^ exp_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx          <= 4'd0;
            cnt          <= 4'd0;
            exp_q        <= 16'd0;
            {A, B, C, D} <= 4'd0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            PASS         <= 1'b0;
            CAPT         <= 16'd0;
            MISMATCH     <= 16'd0;
            FIRST_ERR    <= 4'd0;
            ERR_VALID    <= 1'b0;
        end else begin
            DONE <= last;
            if (accept) begin
                idx          <= 4'd0;
                cnt          <= 4'd0;
                exp_q        <= EXP;
                {A, B, C, D} <= 4'd0;
                BUSY         <= 1'b1;
                CAPT         <= 16'd0;
                PASS         <= 1'b0;
                MISMATCH     <= 16'd0;
                FIRST_ERR    <= 4'd0;
                ERR_VALID    <= 1'b0;
            end else if (state == RUN) begin
                if (sample) begin
                    CAPT <= capt_nxt;
                    cnt  <= 4'd0;
                    if (last) begin
                        idx          <= 4'd0;
                        {A, B, C, D} <= 4'd0;
                        PASS         <= (mis_nxt == 16'd0);
                        MISMATCH     <= mis_nxt;
                        FIRST_ERR    <= lowest_set(mis_nxt);
                        ERR_VALID    <= |mis_nxt;
                    end else begin
                        idx          <= idx + 4'd1;
                        {A, B, C, D} <= idx + 4'd1;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else if (state == FIN) begin
                BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

    localparam int S = 2;
    localparam int T = 16 * (S + 1);

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [15:0] EXP;
    logic        F_IN;
    logic        A, B, C, D, BUSY, DONE, PASS, ERR_VALID;
    logic [15:0] CAPT, MISMATCH;
    logic [3:0]  FIRST_ERR;
    int          fsel;

    logic        start2;
    logic        f2;
    logic        a2, b2, c2, d2, busy2, done2, pass2, errv2;
    logic [15:0] capt2, mis2;
    logic [3:0]  ferr2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    // Function under check, evaluated from the DUT's own minterm outputs.
    assign F_IN = (fsel == 0) ? (A & B) : (fsel == 1) ? 1'b1 : ~D;
    assign f2   = ~d2;

    tt_sweep_checker #(.SETTLE_CYCLES(S)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .EXP(EXP), .F_IN(F_IN),
        .A(A), .B(B), .C(C), .D(D), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .CAPT(CAPT), .MISMATCH(MISMATCH), .FIRST_ERR(FIRST_ERR), .ERR_VALID(ERR_VALID)
    );

    tt_sweep_checker #(.SETTLE_CYCLES(0)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(start2), .EXP(16'h5555), .F_IN(f2),
        .A(a2), .B(b2), .C(c2), .D(d2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .CAPT(capt2), .MISMATCH(mis2), .FIRST_ERR(ferr2), .ERR_VALID(errv2)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic fmodel(input int sel, input int m);
        case (sel)
            0:       return (m >= 12);
            1:       return 1'b1;
            default: return (m % 2) == 0;
        endcase
    endfunction

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    // Reference model: m_t counts cycles since the accepted START (-1 = idle).
    int          m_t = -1;
    logic [15:0] m_exp = 0, m_tab = 0, m_capt = 0, m_mis = 0;
    logic        m_pass = 0, m_errv = 0;
    logic [3:0]  m_first = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_t = -1; m_exp = 0; m_capt = 0; m_mis = 0;
            m_pass = 0; m_errv = 0; m_first = 0;
        end else if (m_t < 0) begin
            if (START) begin
                m_t = 0; m_exp = EXP; m_capt = 0; m_mis = 0;
                m_pass = 0; m_errv = 0; m_first = 0;
                for (int m = 0; m < 16; m++) m_tab[m] = fmodel(fsel, m);
            end
        end else if (m_t == T) begin
            m_t = -1;
        end else begin
            m_t++;
            m_capt = 0;
            for (int m = 0; m < 16; m++)
                if ((m + 1) * (S + 1) <= m_t) m_capt[m] = m_tab[m];
            if (m_t == T) begin
                m_mis   = m_capt ^ m_exp;
                m_pass  = (m_mis == 0);
                m_errv  = |m_mis;
                m_first = lowest(m_mis);
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("abcd",      {12'd0, A, B, C, D},
            {12'd0, (m_t >= 0 && m_t < T) ? 4'(m_t / (S + 1)) : 4'd0});
        chk("busy",      {15'd0, BUSY}, {15'd0, m_t >= 0});
        chk("done",      {15'd0, DONE}, {15'd0, m_t == T});
        chk("capt",      CAPT, m_capt);
        chk("pass",      {15'd0, PASS}, {15'd0, m_pass});
        chk("mismatch",  MISMATCH, m_mis);
        chk("first_err", {12'd0, FIRST_ERR}, {12'd0, m_first});
        chk("err_valid", {15'd0, ERR_VALID}, {15'd0, m_errv});
    end

    task automatic sweep(input int sel, input logic [15:0] e, output int lat);
        repeat (2) @(negedge CLK);
        fsel = sel; EXP = e; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge CLK); #1;
            lat++;
            if (DONE) break;
        end
    endtask

    task automatic check_results(input string tag, input logic [15:0] capt_e, input logic pass_e,
                                 input logic [15:0] mis_e, input logic [3:0] first_e, input logic errv_e);
        chk({tag, "_capt"}, CAPT, capt_e);
        chk({tag, "_pass"}, {15'd0, PASS}, {15'd0, pass_e});
        chk({tag, "_mis"}, MISMATCH, mis_e);
        chk({tag, "_first"}, {12'd0, FIRST_ERR}, {12'd0, first_e});
        chk({tag, "_errv"}, {15'd0, ERR_VALID}, {15'd0, errv_e});
    endtask

    initial begin
        int lat, dones, k;
        RST_N = 1'b0; START = 1'b0; EXP = 16'd0; fsel = 0; start2 = 1'b0;

        // Reset with random inputs
        #1;
        START = 1'($urandom); EXP = 16'($urandom); start2 = 1'($urandom);
        #1;
        chk("rst_abcd", {12'd0, A, B, C, D}, 16'd0);
        chk("rst_busy", {15'd0, BUSY}, 16'd0);
        chk("rst_capt", CAPT, 16'd0);
        chk("rst_done2", {14'd0, done2, busy2}, 16'd0);
        repeat (3) begin
            @(negedge CLK);
            START = 1'($urandom); EXP = 16'($urandom);
        end
        @(negedge CLK);
        RST_N = 1'b1; START = 1'b0; start2 = 1'b0;
        repeat (10) @(negedge CLK);
        chk("idle_busy", {15'd0, BUSY}, 16'd0);
        chk("idle_capt", CAPT, 16'd0);

        // F = A&B
        sweep(0, 16'hF000, lat);
        chk("s2_latency", 16'(lat), 16'd48);
        check_results("s2", 16'hF000, 1'b1, 16'h0000, 4'd0, 1'b0);

        sweep(0, 16'hF0F0, lat);
        check_results("s3a", 16'hF000, 1'b0, 16'h00F0, 4'd4, 1'b1);

        sweep(1, 16'h0000, lat);
        check_results("s3b", 16'hFFFF, 1'b0, 16'hFFFF, 4'd0, 1'b1);

        // START held high, EXP changing every cycle
        repeat (2) @(negedge CLK);
        fsel = 0; START = 1'b1; EXP = 16'($urandom);
        dones = 0;
        repeat (120) begin
            @(negedge CLK);
            EXP = 16'($urandom);
            if (DONE) dones++;
        end
        chk("s4_dones", 16'(dones), 16'd2);
        chk("s4_busy", {15'd0, BUSY}, 16'd1);
        START = 1'b0;
        k = 0;
        while (BUSY && k < 100) begin @(negedge CLK); k++; end
        chk("s4_drain_timeout", {15'd0, BUSY}, 16'd0);

        // Reset mid-sweep
        repeat (2) @(negedge CLK);
        fsel = 1; EXP = 16'($urandom); START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        k = 0;
        while ({A, B, C, D} != 4'd7 && k < 100) begin @(posedge CLK); #1; k++; end
        chk("s5_reach7", {12'd0, A, B, C, D}, 16'd7);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("s5_busy", {15'd0, BUSY}, 16'd0);
        chk("s5_capt", CAPT, 16'd0);
        chk("s5_abcd", {12'd0, A, B, C, D}, 16'd0);
        chk("s5_done", {15'd0, DONE}, 16'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        sweep(0, 16'hF000, lat);
        chk("s5_latency", 16'(lat), 16'd48);
        check_results("s5", 16'hF000, 1'b1, 16'h0000, 4'd0, 1'b0);

        // Zero settle cycles, F = ~D
        @(negedge CLK);
        start2 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start2 = 1'b0;
        k = 0;
        while (k < 40) begin
            @(posedge CLK); #1;
            k++;
            if (done2) break;
            chk("s6_abcd", {12'd0, a2, b2, c2, d2}, 16'(k));
        end
        chk("s6_latency", 16'(k), 16'd16);
        chk("s6_pass", {15'd0, pass2}, 16'd1);
        chk("s6_capt", capt2, 16'h5555);
        chk("s6_errv", {11'd0, errv2, ferr2}, 16'd0);
        chk("s6_mis", mis2, 16'd0);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Sequential stimulus/response companion for the lab's 4-input combinational function blocks (SOP/POS reductions). On START it drives every minterm on A,B,C,D in order and samples the function output F_IN for each. It records the 16-entry truth table and compares it against an expected minterm mask, then reports pass/fail and the first failing minterm. It sits on the board or bench side of a 4-in/1-out function block: it drives the function's inputs and reads back its output.

Parameters:
SETTLE_CYCLES, 2, extra clock cycles each vector is held before F_IN is sampled; legal range 0..15.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  sweep request; sampled only in IDLE.
EXP  in  16  expected truth table; bit i is the expected output for minterm i. Latched on the accepted START.
F_IN  in  1  output of the function under check.
A  out  1  minterm bit 3 (MSB).
B  out  1  minterm bit 2.
C  out  1  minterm bit 1.
D  out  1  minterm bit 0 (LSB).
BUSY  out  1  high from the accepted START until the DONE cycle (inclusive).
DONE  out  1  one-cycle pulse; results are valid from this cycle onward.
PASS  out  1  CAPT == latched EXP.
CAPT  out  16  captured truth table; bit i is F_IN sampled for minterm i.
MISMATCH  out  16  CAPT xor latched EXP.
FIRST_ERR  out  4  lowest set index of MISMATCH; 0 when MISMATCH is 0.
ERR_VALID  out  1  OR-reduction of MISMATCH.

Behaviour:
- Single clock domain, CLK. RST_N is asynchronous assert and synchronous deassert (externally synchronised).
- Reset values: every output is 0, {A,B,C,D}=0000, state=IDLE, index=0, hold counter=0, latched EXP=0.
- FSM states:
  - IDLE: START=1 -> RUN. On that edge: index=0, cnt=0, CAPT=0, latch EXP, BUSY=1; PASS, MISMATCH, FIRST_ERR and ERR_VALID are cleared.
  - RUN: {A,B,C,D}=index. Each edge with cnt<SETTLE_CYCLES increments cnt.
    - At the edge with cnt==SETTLE_CYCLES: CAPT[index]<=F_IN and cnt<=0.
    - If index<15, index increments. If index==15, go to FIN.
  - FIN (exactly one cycle): DONE=1, BUSY=1. PASS, MISMATCH, FIRST_ERR and ERR_VALID are registered from the final CAPT and the latched EXP on the edge entering FIN. Next state is IDLE.
- Outputs are registered; there is no combinational path from F_IN or START to any output.
- Each vector is held for SETTLE_CYCLES+1 cycles. F_IN is sampled on the last edge of that hold.
- Latency: if START is accepted at edge E0, DONE is high between edge E0+16*(SETTLE_CYCLES+1) and the next edge. With the default SETTLE_CYCLES=2, that is 48 cycles.
- {A,B,C,D} returns to 0000 in FIN and IDLE.
- START in RUN or FIN is ignored, with no restart and no queuing. If START is held high, a new sweep begins on the first IDLE edge after FIN.
- EXP changes after acceptance have no effect on the current sweep.
- Results (CAPT, PASS, MISMATCH, FIRST_ERR, ERR_VALID) hold their values in IDLE until the next accepted START.
- Reset mid-sweep: all state and outputs clear immediately, with no DONE pulse. The next START performs a full sweep from minterm 0.
- Index wrap: index never exceeds 15. The FIN transition occurs on the minterm-15 sample edge.

Test Plan:
1. Assert RST_N=0 with random inputs -> all outputs 0 and ABCD=0000 immediately; after release and 10 idle cycles, outputs unchanged.
2. F_IN=A&B modelled behaviourally, EXP=16'hF000, SETTLE_CYCLES=2, pulse START -> ABCD steps 0..15, each value held 3 cycles; DONE 48 cycles after START edge; CAPT=F000, PASS=1, MISMATCH=0000, ERR_VALID=0, FIRST_ERR=0.
3. Same F_IN, EXP=16'hF0F0 -> PASS=0, MISMATCH=00F0, FIRST_ERR=4, ERR_VALID=1. Repeat with F_IN=1, EXP=0000 -> MISMATCH=FFFF, FIRST_ERR=0.
4. Hold START=1 continuously and toggle EXP during the sweep -> exactly one sweep per FIN, a new sweep starts the cycle after FIN, results use the EXP latched at each start.
5. Assert RST_N low while ABCD=0111 -> BUSY, CAPT and ABCD go to 0 asynchronously with no DONE; the next START gives a full correct sweep (as in scenario 2).
6. SETTLE_CYCLES=0, F_IN=~D, EXP=16'h5555 -> one cycle per vector, DONE 16 cycles after START, PASS=1.
